mem_port_arbiter: RTL and testbench

- Shares the single processor memory port between two requesters: the CPU control unit (fetch, lw/sw, push/pop) and a DMA/program loader.
- Grants one requester at a time and latches that requester's address, data and direction.
- Drives READ/WRITE strobes for a fixed memory latency, then returns read data with a one-cycle ACK.
- Sits between the control unit / loader and the memory model, replacing the control unit's direct READ/WRITE connection.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encodings, owner codes
// and the latency-counter width.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Wide enough for the largest legal latency (15).
    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] last_count(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way winner selection between the CPU and the DMA/loader.
// Round-robin favours the requester that was not granted last.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic cpu_req_i,
    input  logic dma_req_i,
    input  logic last_grant_i,
    input  logic priority_mode_i,
    output logic grant_valid_o,
    output logic grant_owner_o
);

    always_comb begin
        grant_valid_o = cpu_req_i | dma_req_i;
        grant_owner_o = OWNER_CPU;
        if (cpu_req_i && dma_req_i) begin
            grant_owner_o = priority_mode_i ? OWNER_CPU : ~last_grant_i;
        end else if (dma_req_i) begin
            grant_owner_o = OWNER_DMA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU control unit and the DMA/loader:
// grants one requester, holds the strobe for MEM_LATENCY cycles, then ACKs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2,
    parameter int PRIORITY_MODE = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
    input  logic [DATA_WIDTH-1:0] CPU_WDATA,
    output logic [DATA_WIDTH-1:0] CPU_RDATA,
    output logic                  CPU_ACK,
    input  logic                  DMA_REQ,
    input  logic                  DMA_WE,
    input  logic [ADDR_WIDTH-1:0] DMA_ADDR,
    input  logic [DATA_WIDTH-1:0] DMA_WDATA,
    output logic [DATA_WIDTH-1:0] DMA_RDATA,
    output logic                  DMA_ACK,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY,
    output logic                  OWNER,
    output logic [1:0]            DBG_STATE
);

    // Handshake: a requester holds REQ (level) until its one-cycle ACK; REQ
    // still high in the IDLE cycle after ACK is taken as a fresh request.
    localparam logic [CNT_W-1:0] LAST_CNT = last_count(MEM_LATENCY);

    arb_state_e            state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  we_q;
    logic                  owner_q;
    logic                  last_grant_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dma_rdata_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  cpu_ack_q;
    logic                  dma_ack_q;

    logic                  grant_valid;
    logic                  grant_owner;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    rr_pick2 u_pick (
        .cpu_req_i       (CPU_REQ),
        .dma_req_i       (DMA_REQ),
        .last_grant_i    (last_grant_q),
        .priority_mode_i (PRIORITY_MODE != 0),
        .grant_valid_o   (grant_valid),
        .grant_owner_o   (grant_owner)
    );

    always_comb begin
        we_d    = CPU_WE;
        addr_d  = CPU_ADDR;
        wdata_d = CPU_WDATA;
        if (grant_owner == OWNER_DMA) begin
            we_d    = DMA_WE;
            addr_d  = DMA_ADDR;
            wdata_d = DMA_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            owner_q      <= OWNER_CPU;
            last_grant_q <= OWNER_DMA;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= grant_owner;
                        last_grant_q <= grant_owner;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        cnt_q        <= '0;
                        mem_read_q   <= ~we_d;
                        mem_write_q  <= we_d;
                        state_q      <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (!we_q && owner_q == OWNER_CPU) cpu_rdata_q <= MEM_RDATA;
                        if (!we_q && owner_q == OWNER_DMA) dma_rdata_q <= MEM_RDATA;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        cpu_ack_q   <= (owner_q == OWNER_CPU);
                        dma_ack_q   <= (owner_q == OWNER_DMA);
                        state_q     <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    state_q   <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign CPU_RDATA = cpu_rdata_q;
    assign CPU_ACK   = cpu_ack_q;
    assign DMA_RDATA = dma_rdata_q;
    assign DMA_ACK   = dma_ack_q;
    assign MEM_READ  = mem_read_q;
    assign MEM_WRITE = mem_write_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign BUSY      = (state_q != ARB_IDLE);
    assign OWNER     = owner_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 round-robin, instance 1 fixed CPU
// priority, both checked every cycle against a timeline model of each access.
module tb_mem_port_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk;
    logic          rst;
    logic          cpu_req[2], cpu_we[2], dma_req[2], dma_we[2];
    logic [AW-1:0] cpu_addr[2], dma_addr[2], mem_addr[2];
    logic [DW-1:0] cpu_wdata[2], dma_wdata[2], mem_wdata[2], mem_rdata[2];
    logic [DW-1:0] cpu_rdata[2], dma_rdata[2];
    logic          cpu_ack[2], dma_ack[2], mem_read[2], mem_write[2];
    logic          busy[2], owner[2];
    logic [1:0]    dbg_state[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(L), .PRIORITY_MODE(g)
        ) u_dut (
            .CLK(clk), .RST(rst),
            .CPU_REQ(cpu_req[g]), .CPU_WE(cpu_we[g]), .CPU_ADDR(cpu_addr[g]),
            .CPU_WDATA(cpu_wdata[g]), .CPU_RDATA(cpu_rdata[g]), .CPU_ACK(cpu_ack[g]),
            .DMA_REQ(dma_req[g]), .DMA_WE(dma_we[g]), .DMA_ADDR(dma_addr[g]),
            .DMA_WDATA(dma_wdata[g]), .DMA_RDATA(dma_rdata[g]), .DMA_ACK(dma_ack[g]),
            .MEM_READ(mem_read[g]), .MEM_WRITE(mem_write[g]), .MEM_ADDR(mem_addr[g]),
            .MEM_WDATA(mem_wdata[g]), .MEM_RDATA(mem_rdata[g]),
            .BUSY(busy[g]), .OWNER(owner[g]), .DBG_STATE(dbg_state[g])
        );
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst %0d] t=%0t got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Memory contents; data is only valid on the last strobe cycle of a read.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 26'h10) return 32'hDEADBEEF;
        return {a[5:0], a} ^ 32'hA5C30F17;
    endfunction

    int rd_run[2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_read[i] === 1'b1 && rd_run[i] == L - 1) mem_rdata[i] = mem_fn(mem_addr[i]);
            else mem_rdata[i] = $urandom;
            rd_run[i] = (mem_read[i] === 1'b1) ? rd_run[i] + 1 : 0;
        end
    end

    // ---------------- behavioural model ----------------
    // m_phase: 0 = free, 1..L = strobe cycles of the access, L+1 = ACK cycle.
    int            m_phase[2];
    logic          m_we[2], m_owner[2], m_last[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wdata[2], m_rd_cpu[2], m_rd_dma[2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_phase[i] = 0; m_we[i] = 0; m_owner[i] = 0; m_last[i] = 1;
                m_addr[i] = '0; m_wdata[i] = '0; m_rd_cpu[i] = '0; m_rd_dma[i] = '0;
            end else if (m_phase[i] == 0) begin
                if (cpu_req[i] || dma_req[i]) begin
                    if (cpu_req[i] && dma_req[i]) m_owner[i] = (i == 1) ? 1'b0 : !m_last[i];
                    else m_owner[i] = dma_req[i];
                    m_last[i]  = m_owner[i];
                    m_we[i]    = m_owner[i] ? dma_we[i] : cpu_we[i];
                    m_addr[i]  = m_owner[i] ? dma_addr[i] : cpu_addr[i];
                    m_wdata[i] = m_owner[i] ? dma_wdata[i] : cpu_wdata[i];
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] <= L) begin
                if (m_phase[i] == L && !m_we[i]) begin
                    if (m_owner[i]) m_rd_dma[i] = mem_fn(m_addr[i]);
                    else m_rd_cpu[i] = mem_fn(m_addr[i]);
                end
                m_phase[i]++;
            end else begin
                m_phase[i] = 0;
            end
        end
    end

    // ---------------- per-cycle compare + grant monitor ----------------
    logic busy_prev[2];
    bit   own0_q[$], own1_q[$];
    int   cyc0_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit strobe;
                int exp_state;
                strobe = (m_phase[i] >= 1 && m_phase[i] <= L);
                exp_state = (m_phase[i] == 0) ? 0 : (m_phase[i] <= L) ? 1 : 2;
                chk("mem_read", i, mem_read[i], strobe && !m_we[i]);
                chk("mem_write", i, mem_write[i], strobe && m_we[i]);
                chk("strobe_excl", i, mem_read[i] & mem_write[i], 0);
                if (strobe) chk("mem_addr", i, mem_addr[i], m_addr[i]);
                if (strobe && m_we[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
                chk("cpu_ack", i, cpu_ack[i], m_phase[i] == L + 1 && !m_owner[i]);
                chk("dma_ack", i, dma_ack[i], m_phase[i] == L + 1 && m_owner[i]);
                chk("cpu_rdata", i, cpu_rdata[i], m_rd_cpu[i]);
                chk("dma_rdata", i, dma_rdata[i], m_rd_dma[i]);
                chk("busy", i, busy[i], m_phase[i] != 0);
                chk("owner", i, owner[i], m_owner[i]);
                chk("state", i, dbg_state[i], exp_state);
                if (busy[i] && !busy_prev[i]) begin
                    if (i == 0) begin own0_q.push_back(owner[0]); cyc0_q.push_back(cyc); end
                    else own1_q.push_back(owner[1]);
                end
                busy_prev[i] = busy[i];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cpu(input int i, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req[i] = req; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
    endtask

    task automatic set_dma(input int i, input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req[i] = req; dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = d;
    endtask

    task automatic rand_cpu(input int i);
        set_cpu(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
    endtask

    task automatic rand_dma(input int i);
        set_dma(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom);
    endtask

    task automatic drive_random(input int i);
        if (cpu_req[i]) begin
            if (cpu_ack[i]) begin
                if ($urandom_range(0, 1) == 0) cpu_req[i] = 1'b0;
                else rand_cpu(i);
            end else if ($urandom_range(0, 49) == 0) cpu_req[i] = 1'b0;
            else if ($urandom_range(0, 9) == 0) begin
                cpu_addr[i] = AW'($urandom); cpu_wdata[i] = $urandom; cpu_we[i] = ~cpu_we[i];
            end
        end else if ($urandom_range(0, 3) == 0) rand_cpu(i);
        if (dma_req[i]) begin
            if (dma_ack[i]) begin
                if ($urandom_range(0, 1) == 0) dma_req[i] = 1'b0;
                else rand_dma(i);
            end else if ($urandom_range(0, 49) == 0) dma_req[i] = 1'b0;
            else if ($urandom_range(0, 9) == 0) begin
                dma_addr[i] = AW'($urandom); dma_wdata[i] = $urandom; dma_we[i] = ~dma_we[i];
            end
        end else if ($urandom_range(0, 3) == 0) rand_dma(i);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit exp_rr[4];
        bit got;
        int n1;
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_cpu(i, 1'b1, 1'b0, '0, '0);
            set_dma(i, 1'b1, 1'b1, '0, '0);
        end
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_mem_read", i, mem_read[i], 0);
            chk("rst_mem_write", i, mem_write[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_acks", i, {cpu_ack[i], dma_ack[i]}, 0);
            chk("rst_mem_addr", i, mem_addr[i], 0);
            chk("rst_cpu_rdata", i, cpu_rdata[i], 0);
        end
        rst = 1'b0;

        // Contention: both held high; first tie goes to the CPU.
        @(negedge clk);
        chk("first_busy", 0, busy[0], 1);
        chk("first_owner", 0, owner[0], 0);
        chk("first_owner", 1, owner[1], 0);
        repeat (16) @(negedge clk);
        #1;
        chk("rr_grant_count", 0, own0_q.size() >= 4, 1);
        chk("prio_grant_count", 1, own1_q.size() >= 3, 1);
        for (int k = 0; k < 4 && k < own0_q.size(); k++) chk("rr_owner_seq", 0, own0_q[k], exp_rr[k]);
        for (int k = 1; k < 4 && k < cyc0_q.size(); k++) chk("rr_spacing", 0, cyc0_q[k] - cyc0_q[k-1], 4);
        for (int k = 0; k < own1_q.size(); k++) chk("prio_cpu_wins", 1, own1_q[k], 0);

        // CPU drops: priority instance must now serve the DMA.
        for (int i = 0; i < 2; i++) cpu_req[i] = 1'b0;
        @(negedge clk);
        #1;
        n1 = own1_q.size();
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            #1;
            if (own1_q.size() > n1) got = 1'b1;
        end
        chk("prio_dma_granted", 1, got, 1);
        if (got) chk("prio_dma_owner", 1, own1_q[n1], 1);
        for (int i = 0; i < 2; i++) dma_req[i] = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_before_read", 0, busy[0], 0);

        // Single CPU read at 0x10.
        for (int i = 0; i < 2; i++) set_cpu(i, 1'b1, 1'b0, 26'h10, '0);
        @(negedge clk);
        chk("rd_c1_read", 0, mem_read[0], 1);
        chk("rd_c1_addr", 0, mem_addr[0], 26'h10);
        @(negedge clk);
        chk("rd_c2_read", 0, mem_read[0], 1);
        @(negedge clk);
        chk("rd_ack", 0, cpu_ack[0], 1);
        chk("rd_data", 0, cpu_rdata[0], 32'hDEADBEEF);
        chk("rd_no_dma_ack", 0, dma_ack[0], 0);
        for (int i = 0; i < 2; i++) cpu_req[i] = 1'b0;
        @(negedge clk);

        // DMA write, address changes mid-access.
        for (int i = 0; i < 2; i++) set_dma(i, 1'b1, 1'b1, 26'h100, 32'h12345678);
        @(negedge clk);
        chk("wr_c1_write", 0, mem_write[0], 1);
        chk("wr_c1_addr", 0, mem_addr[0], 26'h100);
        chk("wr_c1_data", 0, mem_wdata[0], 32'h12345678);
        for (int i = 0; i < 2; i++) begin dma_addr[i] = 26'h200; dma_wdata[i] = $urandom; end
        @(negedge clk);
        chk("wr_c2_write", 0, mem_write[0], 1);
        chk("wr_c2_addr", 0, mem_addr[0], 26'h100);
        chk("wr_c2_data", 0, mem_wdata[0], 32'h12345678);
        @(negedge clk);
        chk("wr_ack", 0, dma_ack[0], 1);
        chk("wr_no_cpu_ack", 0, cpu_ack[0], 0);
        chk("wr_dma_rdata_held", 0, dma_rdata[0], 0);
        for (int i = 0; i < 2; i++) dma_req[i] = 1'b0;
        @(negedge clk);

        // Reset in cycle 1 of a CPU read.
        for (int i = 0; i < 2; i++) set_cpu(i, 1'b1, 1'b0, 26'h20, '0);
        @(negedge clk);
        chk("ra_c1_read", 0, mem_read[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("ra_read_off", 0, mem_read[0], 0);
        chk("ra_busy", 0, busy[0], 0);
        chk("ra_state_idle", 0, dbg_state[0], 2'b00);
        chk("ra_no_ack", 0, cpu_ack[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ra_regrant", 0, mem_read[0], 1);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack[0]) got = 1'b1;
        end
        chk("ra_ack_arrives", 0, got, 1);
        for (int i = 0; i < 2; i++) cpu_req[i] = 1'b0;
        @(negedge clk);

        // Randomized traffic with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) drive_random(i);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin cpu_req[i] = 1'b0; dma_req[i] = 1'b0; end
        repeat (8) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
